// File: rtl/contador_mod_updown.sv
// Modulo-M up/down counter with enable prescaler, synchronous load/clear, tc level and wrap pulse.
// Build option CONTADOR_SATURATE_EN: hold at 0 / M-1 instead of wrapping; wrap then never asserts.
module contador_mod_updown #(
  parameter int N   = 4,
  parameter int M   = 10,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         clr,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         wrap
);

  localparam int              PW     = (DIV > 1) ? $clog2(DIV) : 1;
  // M-1 is formed in int arithmetic so M == 2^N does not overflow
  localparam logic [N-1:0]    Q_MAX  = N'(M - 1);
  localparam logic [PW-1:0]   P_LAST = PW'(DIV - 1);

  if (M < 2 || M > (1 << N)) begin : g_bad_m
    $error("contador_mod_updown: M must satisfy 2 <= M <= 2^N");
  end
  if (DIV < 1) begin : g_bad_div
    $error("contador_mod_updown: DIV must be >= 1");
  end

  logic [PW-1:0] p;
  logic [PW-1:0] p_nxt;
  logic [N-1:0]  q_nxt;
  logic          wrap_nxt;
  logic          step;
  logic          at_max;
  logic          at_zero;

  assign at_max  = (q == Q_MAX);
  assign at_zero = (q == '0);
  assign tc      = up ? at_max : at_zero;
  assign step    = en && (p == P_LAST);

  always_comb begin
    p_nxt    = p;
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (clr) begin
      p_nxt = '0;
      q_nxt = '0;
    end else if (load) begin
      p_nxt = '0;
      q_nxt = (d > Q_MAX) ? Q_MAX : d;
    end else if (en) begin
      p_nxt = step ? '0 : p + PW'(1);
      if (step) begin
        if (up) begin
          if (!at_max) begin
            q_nxt = q + N'(1);
          end else begin
`ifndef CONTADOR_SATURATE_EN
            q_nxt    = '0;
            wrap_nxt = 1'b1;
`endif
          end
        end else begin
          if (!at_zero) begin
            q_nxt = q - N'(1);
          end else begin
`ifndef CONTADOR_SATURATE_EN
            q_nxt    = Q_MAX;
            wrap_nxt = 1'b1;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q    <= '0;
      p    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      p    <= p_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_contador_mod_updown.sv
// Bench for contador_mod_updown: three instances (M=10/DIV=1, M=10/DIV=3, M=16/DIV=1) on shared inputs,
// checked against a behavioural model through a scoreboard queue plus a table of hand-derived vectors.
module tb_contador_mod_updown;

  logic       clk = 1'b0;
  logic       reset, en, up, load, clr;
  logic [3:0] d;
  logic [3:0] q_a, q_b, q_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;

  contador_mod_updown #(.N(4), .M(10), .DIV(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d), .clr(clr),
    .q(q_a), .tc(tc_a), .wrap(wrap_a));
  contador_mod_updown #(.N(4), .M(10), .DIV(3)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d), .clr(clr),
    .q(q_b), .tc(tc_b), .wrap(wrap_b));
  contador_mod_updown #(.N(4), .M(16), .DIV(1)) dut_c (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d), .clr(clr),
    .q(q_c), .tc(tc_c), .wrap(wrap_c));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       wrap;
  } obs_t;

  typedef struct {
    logic       rst, en, up, ld;
    logic [3:0] d;
    logic       clr;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];
  obs_t sb[$];
  int   mq[3];
  int   mp[3];
  int   mm[3]   = '{10, 10, 16};
  int   mdiv[3] = '{1, 3, 1};
  int   n_vec   = 0;
  int   n_miss  = 0;

  function automatic obs_t model_step(int i, logic r, logic e, logic u, logic l,
                                      logic [3:0] dv, logic c);
    obs_t o;
    bit   w   = 1'b0;
    bit   stp = 1'b0;
    if (!r || c) begin
      mq[i] = 0;
      mp[i] = 0;
    end else if (l) begin
      mq[i] = (int'(dv) > mm[i] - 1) ? mm[i] - 1 : int'(dv);
      mp[i] = 0;
    end else if (e) begin
      if (mp[i] == mdiv[i] - 1) begin
        mp[i] = 0;
        stp   = 1'b1;
      end else begin
        mp[i]++;
      end
      if (stp) begin
        if (u) begin
          if (mq[i] < mm[i] - 1) mq[i]++;
          else begin
`ifndef CONTADOR_SATURATE_EN
            mq[i] = 0;
            w     = 1'b1;
`endif
          end
        end else begin
          if (mq[i] > 0) mq[i]--;
          else begin
`ifndef CONTADOR_SATURATE_EN
            mq[i] = mm[i] - 1;
            w     = 1'b1;
`endif
          end
        end
      end
    end
    o.q    = 4'(mq[i]);
    o.tc   = u ? (mq[i] == mm[i] - 1) : (mq[i] == 0);
    o.wrap = w;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t act);
    obs_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL %s: scoreboard empty, got q=%0d tc=%0b wrap=%0b", nm, act.q, act.tc, act.wrap);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        n_miss++;
        $display("FAIL %s @%0t: got q=%0d tc=%0b wrap=%0b, want q=%0d tc=%0b wrap=%0b",
                 nm, $time, act.q, act.tc, act.wrap, e.q, e.tc, e.wrap);
      end
    end
  endtask

  task automatic chk_val(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                       input logic [3:0] dv, input logic c, input bit has_exp, input obs_t exp_a);
    reset = r; en = e; up = u; load = l; d = dv; clr = c;
    for (int i = 0; i < 3; i++) sb.push_back(model_step(i, r, e, u, l, dv, c));
    if (has_exp) sb.push_back(exp_a);
    @(posedge clk);
    #1;
    check("model_a", {q_a, tc_a, wrap_a});
    check("model_b", {q_b, tc_b, wrap_b});
    check("model_c", {q_c, tc_c, wrap_c});
    if (has_exp) check("table_a", {q_a, tc_a, wrap_a});
  endtask

  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [3:0] dv, input logic c);
    cycle(r, e, u, l, dv, c, 1'b0, '0);
  endtask

  function automatic void add(input logic r, input logic e, input logic u, input logic l,
                              input logic [3:0] dv, input logic c,
                              input logic [3:0] eq, input logic etc, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.ld = l; v.d = dv; v.clr = c;
    v.exp.q = eq; v.exp.tc = etc; v.exp.wrap = ew;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; d = '0; clr = 1'b0;
    foreach (mq[i]) begin mq[i] = 0; mp[i] = 0; end

    // rst en up ld d clr | q tc wrap   (expectations for instance a: M=10, DIV=1)
    add(0, 0, 1, 0, 0, 0,  0, 0, 0);
    for (int k = 1; k <= 9; k++) add(1, 1, 1, 0, 0, 0, 4'(k), (k == 9), 0);
`ifdef CONTADOR_SATURATE_EN
    add(1, 1, 1, 0, 0, 0,  9, 1, 0);
    add(1, 1, 1, 0, 0, 0,  9, 1, 0);
    add(1, 1, 1, 0, 0, 0,  9, 1, 0);
    add(1, 1, 0, 0, 0, 0,  8, 0, 0);
`else
    add(1, 1, 1, 0, 0, 0,  0, 0, 1);
    add(1, 1, 1, 0, 0, 0,  1, 0, 0);
    add(1, 1, 1, 0, 0, 0,  2, 0, 0);
    add(1, 1, 0, 0, 0, 0,  1, 0, 0);
`endif
    add(1, 1, 1, 0, 0, 1,  0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  0, 1, 0);
`ifdef CONTADOR_SATURATE_EN
    add(1, 1, 0, 0, 0, 0,  0, 1, 0);
    add(1, 1, 0, 0, 0, 0,  0, 1, 0);
`else
    add(1, 1, 0, 0, 0, 0,  9, 0, 1);
    add(1, 1, 0, 0, 0, 0,  8, 0, 0);
`endif
    add(1, 0, 0, 1, 7, 0,  7, 0, 0);
    add(1, 0, 1, 1, 13, 0, 9, 1, 0);
    add(1, 1, 1, 1, 5, 1,  0, 0, 0);
    add(1, 1, 1, 1, 3, 0,  3, 0, 0);
    add(1, 1, 1, 0, 0, 0,  4, 0, 0);
    add(1, 0, 1, 0, 0, 0,  4, 0, 0);
    add(1, 0, 1, 1, 5, 0,  5, 0, 0);
    add(0, 1, 1, 1, 8, 0,  0, 0, 0);
    add(1, 1, 1, 0, 0, 0,  1, 0, 0);
    add(1, 1, 0, 1, 9, 0,  9, 0, 0);
    add(1, 1, 0, 0, 0, 0,  8, 0, 0);
    add(1, 1, 0, 1, 0, 0,  0, 1, 0);
    add(1, 0, 1, 1, 15, 0, 9, 1, 0);

    foreach (vecs[i])
      cycle(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].d, vecs[i].clr, 1'b1, vecs[i].exp);

    // DIV=3: en low for two cycles delays the step by exactly two cycles
    step(1, 0, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk_val("div3_hold_no_step", q_b, 4'd0);
    step(1, 1, 1, 0, 0, 0);
    chk_val("div3_before_step", q_b, 4'd0);
    step(1, 1, 1, 0, 0, 0);
    chk_val("div3_step", q_b, 4'd1);

    // reset in mid-prescale discards p
    step(1, 0, 1, 1, 5, 0);
    step(1, 1, 1, 0, 0, 0);
    chk_val("div3_pre_reset", q_b, 4'd5);
    step(0, 1, 1, 0, 0, 0);
    chk_val("div3_reset_q", q_b, 4'd0);
    chk_val("div3_reset_wrap", {3'b0, wrap_b}, 4'd0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk_val("div3_after_reset_wait", q_b, 4'd0);
    step(1, 1, 1, 0, 0, 0);
    chk_val("div3_after_reset_step", q_b, 4'd1);

    // load while enabled restarts the prescaler
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 2, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk_val("div3_load_restart_wait", q_b, 4'd2);
    step(1, 1, 1, 0, 0, 0);
    chk_val("div3_load_restart_step", q_b, 4'd3);

    // M = 2^N: full-range wrap at 15
    step(1, 0, 1, 1, 15, 0);
    chk_val("m16_load15_tc", {3'b0, tc_c}, 4'd1);
    step(1, 1, 1, 0, 0, 0);
`ifdef CONTADOR_SATURATE_EN
    chk_val("m16_top_hold", q_c, 4'd15);
`else
    chk_val("m16_top_wrap_q", q_c, 4'd0);
    chk_val("m16_top_wrap_pulse", {3'b0, wrap_c}, 4'd1);
`endif

    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 29) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 14) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 19) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/contador_mod_updown.md
Name: contador_mod_updown

Overview:
- Parametrised modulo-M up/down counter, successor to the free-running N-bit counter.
- Adds count enable, direction, synchronous load and clear, an internal enable prescaler, a terminal-count flag and a wrap pulse.
- Used as the building block for cascaded time-keeping stages (seconds/minutes/hours) and other digit counters.
- Stages chain by feeding one stage's wrap into the next stage's en.

Parameters:
N, 4, counter width in bits
M, 10, modulus; q counts 0..M-1; legal range 2 <= M <= 2^N
DIV, 1, prescaler ratio; q steps once per DIV enabled cycles; DIV >= 1

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous reset, active-low; sampled on rising clk
en  input  1  count enable; advances the prescaler
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous load strobe
d  input  N  load value
clr  input  1  synchronous clear strobe
q  output  N  current count
tc  output  1  terminal count flag, combinational from q and up
wrap  output  1  registered one-cycle pulse on wrap-around

Behaviour:
- All state updates on rising clk. No asynchronous paths.
- Reset (reset==0): q=0, wrap=0, prescaler p=0 on the next edge. tc then reflects q=0.
- Priority per edge: reset > clr > load > count.
- clr=1: q=0, p=0, wrap=0.
- load=1:
  - q = d if d <= M-1, else q = M-1 (clamped).
  - p=0, wrap=0.
  - Load ignores en.
- Prescaler p, width clog2(DIV) (minimum 1 bit):
  - en=1: p increments; when p==DIV-1 the edge is a step edge and p wraps to 0.
  - en=0: p holds and no step occurs.
  - DIV=1: every enabled edge is a step edge.
- Step edge, up=1: q = q+1 if q < M-1, else q = 0 with wrap=1 on that same edge.
- Step edge, up=0: q = q-1 if q > 0, else q = M-1 with wrap=1.
- Every non-wrapping edge: wrap=0. wrap is high for exactly one cycle, coincident with the new q value.
- tc = (up && q==M-1) || (!up && q==0). Pure level; ignores en and p.
- Direction change: takes effect on the next step edge. p is not disturbed.
- Arithmetic:
  - All compares are N bits wide.
  - M == 2^N is legal: q wraps naturally, and M-1 is computed without overflow.
- Reset asserted mid-prescale discards the accumulated p.
- Simultaneous load and clr: clr wins.

Optional Feature:
Macro CONTADOR_SATURATE_EN.
- Defined:
  - Up at q==M-1 holds q. Down at q==0 holds q.
  - wrap never asserts (tied 0).
  - tc is unchanged.
  - The prescaler keeps running.
- Undefined: wrap-around behaviour as specified above.
- Load, clear and reset are identical in both builds.

Test Plan:
1. N=4 M=10 DIV=1. Release reset, en=1, up=1 for 12 cycles -> q: 1..9, 0, 1, 2. wrap high only on the edge where q becomes 0. tc high while q==9.
2. Same config, q=0, up=0, en=1 for 2 cycles -> q=9 with wrap=1, then q=8 with wrap=0. tc=1 while q==0 and up=0.
3. DIV=3, en=1 -> q increments every 3rd edge. Toggle en=0 for 2 cycles after the first enabled edge -> the next step is delayed exactly 2 cycles (p held).
4. load=1, d=7 -> q=7 next edge. load=1, d=13 -> q=9 (clamped). load and clr together -> q=0. load during en=1 restarts the prescaler, so the first step comes DIV enabled edges later.
5. reset=0 while q=5, p mid-count, en=1 -> next edge q=0, wrap=0, p=0. Counting resumes from 0 one full DIV period after reset=1.
6. Build with CONTADOR_SATURATE_EN, up=1, q=8, 3 step edges -> q: 9, 9, 9, wrap stays 0. Switch up=0 -> q=8.
